// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state codes, frame size, default timing and frame builder.
package ps2_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // Bits the host drives after the start bit: 8 data, odd parity, stop.
  localparam int PS2_FRAME_BITS = 10;

  // 100 us inhibit and 15 ms clock timeout at 50 MHz.
  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 750000;

  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake of the PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (output tx_data, output tx_start,
                  input  tx_busy, input  tx_done, input tx_error);
  modport slave  (input  tx_data, input  tx_start,
                  output tx_busy, output tx_done, output tx_error);
endinterface

// File: rtl/ps2_line_sync.sv
// 2-FF synchronizers for the raw PS/2 clock/data lines plus a registered
// falling-edge strobe on the synchronized clock. Shared with the receive path.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic sync_clk,
  output logic sync_data,
  output logic fall
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_q, fall_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], clk_in};
    data_sync_d = {data_sync_q[0], data_in};
    clk_prev_d  = clk_sync_q[1];
    fall_d      = clk_prev_q & ~clk_sync_q[1];
  end

  // Idle lines are high; resetting to 1 keeps reset release from faking an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      fall_q      <= fall_d;
    end
  end

  assign sync_clk  = clk_sync_q[1];
  assign sync_data = data_sync_q[1];
  assign fall      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send inhibit, bit shifting
// on device clock falls, ACK check and a no-clock timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  ps2_host_tx_if.slave       host,
  input  logic               ps2_clk_in,
  input  logic               ps2_data_in,
  output logic               ps2_clk_oe,
  output logic               ps2_data_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic sync_clk, sync_data, fall;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .sync_clk  (sync_clk),
    .sync_data (sync_data),
    .fall      (fall)
  );

  logic [2:0]                state_q, state_d;
  logic [PS2_FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]          inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
  logic                      data_oe_q, data_oe_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      dev_phase, to_hit;

  // Phases where the device owns the clock and may go silent.
  assign dev_phase = (state_q == ST_SHIFT) || (state_q == ST_ACK) ||
                     (state_q == ST_WAIT_IDLE);
  assign to_hit    = dev_phase && !fall && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (to_hit) begin
      state_d   = ST_IDLE;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
    end else begin
      if (dev_phase) to_cnt_d = fall ? '0 : to_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          data_oe_d = 1'b0;
          if (host.tx_start) begin
            shift_d   = ps2_frame(host.tx_data);
            inh_cnt_d = '0;
            state_d   = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt_q == INH_LAST) begin
            data_oe_d = 1'b1;
            state_d   = ST_START;
          end else begin
            inh_cnt_d = inh_cnt_q + 1'b1;
          end
        end
        ST_START: begin
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          state_d   = ST_SHIFT;
        end
        ST_SHIFT: begin
          // Open-drain: pull low for a 0, release for a 1.
          if (fall) begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_BIT) state_d = ST_ACK;
          end
        end
        ST_ACK: begin
          data_oe_d = 1'b0;
          if (fall) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (!sync_data) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (sync_clk && sync_data) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: begin
          data_oe_d = 1'b0;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Decoded from state so reset releases the clock line without waiting for an edge.
  assign ps2_clk_oe    = (state_q == ST_INHIBIT) || (state_q == ST_START);
  assign ps2_data_oe   = data_oe_q;
  assign host.tx_busy  = (state_q != ST_IDLE);
  assign host.tx_done  = done_q;
  assign host.tx_error = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench: behavioural PS/2 device on open-drain lines, frame model
// built from byte arithmetic, pulse counters for done/error.
module tb_ps2_host_tx;

  localparam int INH       = 40;
  localparam int TO        = 400;
  localparam int RTS_LIMIT = INH + 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_oe, data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic ps2_clk_line, ps2_data_line;

  ps2_host_tx_if hif ();

  assign ps2_clk_line  = !(clk_oe  || dev_clk_low);
  assign ps2_data_line = !(data_oe || dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (hif),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (clk_oe),
    .ps2_data_oe (data_oe)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int inh_run = 0, inh_len = 0;
  int dev_falls = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters and length of the clock-only inhibit run preceding the start bit.
  always @(negedge clk) begin
    if (hif.tx_done) done_cnt <= done_cnt + 1;
    if (hif.tx_error) err_cnt <= err_cnt + 1;
    if (hif.tx_done && hif.tx_error) both_cnt <= both_cnt + 1;
    if (rst || !clk_oe) inh_run <= 0;
    else if (!data_oe) inh_run <= inh_run + 1;
    else inh_len <= inh_run;
  end

  // What the device should see: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((b >> i) % 2) == 1;
    f[9]  = ($countones(b) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic host_send(input logic [7:0] b);
    @(negedge clk);
    hif.tx_data  = b;
    hif.tx_start = 1'b1;
    @(negedge clk);
    hif.tx_start = 1'b0;
    check("busy_after_start", hif.tx_busy, 1);
  endtask

  task automatic wait_rts(output bit ok);
    int t = 0;
    while (ps2_clk_line !== 1'b0 && t < RTS_LIMIT) begin @(negedge clk); t++; end
    while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && t < RTS_LIMIT) begin
      @(negedge clk); t++;
    end
    ok = (t < RTS_LIMIT);
  endtask

  task automatic dev_recv(input int half, input bit ack, output logic [10:0] got, output bit ok);
    got = '0;
    dev_falls = 0;
    wait_rts(ok);
    if (!ok) return;
    got[0] = ps2_data_line;
    repeat (half) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1; dev_falls++;
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b0;
      got[i] = ps2_data_line;
      repeat (half) @(negedge clk);
    end
    if (ack) dev_data_low = 1'b1;
    repeat (half / 2) @(negedge clk);
    dev_clk_low = 1'b1; dev_falls++;
    repeat (half) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (half / 2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (hif.tx_busy && t < 600) begin @(negedge clk); t++; end
    check(tag, t >= 600, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, input int half, input bit ack);
    int d0, e0;
    logic [10:0] got;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    host_send(b);
    dev_recv(half, ack, got, ok);
    check("rts_seen", ok, 1);
    check("frame", got, model_frame(b));
    wait_idle("complete");
    check("inhibit_len", inh_len, INH);
    check("done_pulses", done_cnt - d0, ack ? 1 : 0);
    check("error_pulses", err_cnt - e0, ack ? 0 : 1);
    check("idle_outputs", {clk_oe, data_oe, hif.tx_busy}, 0);
  endtask

  initial begin : wdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    bit ok;
    int d0, n, seen;
    hif.tx_data  = '0;
    hif.tx_start = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_outputs", {clk_oe, data_oe, hif.tx_busy, hif.tx_done, hif.tx_error}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    xfer(8'hED, 25, 1'b1);
    xfer(8'hF4, 20, 1'b1);
    xfer(8'h00, 15, 1'b1);
    xfer(8'h9B, 18, 1'b0);
    for (int k = 0; k < 6; k++)
      xfer(8'($urandom_range(0, 255)), $urandom_range(12, 30), $urandom_range(0, 3) != 0);

    // Device never clocks: error exactly TO cycles after clock release.
    d0 = done_cnt;
    host_send(8'h42);
    n = 0;
    while (!clk_oe && n < RTS_LIMIT) begin @(negedge clk); n++; end
    while (clk_oe && n < RTS_LIMIT) begin @(negedge clk); n++; end
    n = 0;
    while (!hif.tx_error && n < TO + 50) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TO);
    check("timeout_lines", {clk_oe, data_oe, hif.tx_busy}, 0);
    check("timeout_no_done", done_cnt - d0, 0);

    // Asynchronous reset after the 5th fall, mid frame.
    host_send(8'hA7);
    wait_rts(ok);
    check("rst_rts", ok, 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dev_clk_low = 1'b1; repeat (20) @(negedge clk);
      dev_clk_low = 1'b0; repeat (20) @(negedge clk);
    end
    dev_clk_low = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_rst_state", {data_oe, hif.tx_busy}, 2'b11);
    #2 rst = 1'b1;
    #1 check("async_rst", {clk_oe, data_oe, hif.tx_busy}, 0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    xfer(8'hFF, 20, 1'b1);

    // tx_start while busy is dropped, not queued.
    d0 = done_cnt;
    fork
      dev_recv(16, 1'b1, got, ok);
      begin
        host_send(8'h3C);
        repeat (10) @(negedge clk);
        host_send(8'h55);
        n = 0;
        while (dev_falls < 3 && n < 2000) begin @(negedge clk); n++; end
        host_send(8'h55);
      end
    join
    check("busy_rts", ok, 1);
    check("busy_frame", got, model_frame(8'h3C));
    wait_idle("busy_complete");
    check("busy_done", done_cnt - d0, 1);
    seen = 0;
    repeat (3 * INH) begin @(negedge clk); if (clk_oe || hif.tx_busy) seen = 1; end
    check("no_queued_send", seen, 0);

    check("done_error_exclusive", both_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
